digital_filter: RTL and testbench

//  Deglitch/persistence filter on the phase-frequency-detector UP/DN pulses of the ADPLL.

---
 rtl/digital_filter_pkg.sv | 11 +
 rtl/digital_filter_pulse_qualifier.sv | 87 ++++++++
 rtl/digital_filter.sv | 55 +++++
 tb/tb_digital_filter.sv | 148 ++++++++++++++
 4 files changed

// File: rtl/digital_filter_pkg.sv
// Shared helpers for the PFD UP/DN deglitch filter.
package digital_filter_pkg;

    // Bits needed to hold values 0..n, never less than one bit.
    function automatic int cnt_width(input int n);
        int w;
        w = $clog2(n + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/digital_filter_pulse_qualifier.sv
// One filter channel: input synchronizer, symmetric persistence counter and
// minimum-high hold. The 'out' port carries the qualified value the channel
// will hold after the coming edge, so the top-level output register lines up
// with the qualifier state and adds no extra cycle of latency.
module pulse_qualifier
    import digital_filter_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int THRESH      = 1,
    parameter int MIN_HIGH    = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic in,
    output logic out
);

    localparam int CW = cnt_width(THRESH);
    localparam int HW = cnt_width(MIN_HIGH);
    localparam logic [CW-1:0] THRESH_C = CW'(THRESH);
    localparam logic [HW-1:0] HOLD_C   = HW'(MIN_HIGH);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sample;
    logic                   state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d, cnt_inc;
    logic [HW-1:0]          hold_q, hold_d;
    logic                   hold_busy;

    // Metastability synchronizer: shift the raw asynchronous input through the flop chain.
    // NOTE: sequential blocks use non-blocking (<=) so every flop samples the pre-edge
    // value of its neighbour; blocking here would collapse the chain into one stage.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], in};
        end
    end

    assign sample    = sync_q[SYNC_STAGES-1];
    assign hold_busy = state_q && (hold_q != '0);

    // Persistence and hold: count disagreeing samples, switch state once THRESH is met
    // and the minimum-high hold (if any) has run out.
    // NOTE: every signal written here gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hold_d  = hold_q;
        cnt_inc = (cnt_q == THRESH_C) ? cnt_q : cnt_q + CW'(1);

        if (hold_busy) begin
            hold_d = hold_q - HW'(1);
        end

        if (sample == state_q) begin
            cnt_d = '0;
        end else if ((cnt_inc == THRESH_C) && !hold_busy) begin
            state_d = sample;
            cnt_d   = '0;
            if (sample) begin
                hold_d = HOLD_C;
            end
        end else begin
            // Either still accumulating or saturated while the hold blocks deassertion.
            cnt_d = cnt_inc;
        end
    end

    // Qualifier state registers; reset discards all pulse history.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= 1'b0;
            cnt_q   <= '0;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hold_q  <= hold_d;
        end
    end

    assign out = state_d;

endmodule

// File: rtl/digital_filter.sv
// Deglitch/persistence filter for the ADPLL PFD UP/DN pulses. Two independent
// qualifier channels feed a registered output stage that forces both outputs
// low whenever both channels qualify at once (PFD reset overlap).
module digital_filter
    import digital_filter_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int THRESH      = 1,
    parameter int MIN_HIGH    = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic UP_in,
    input  logic DN_in,
    output logic UP_out,
    output logic DN_out
);

    logic up_q;
    logic dn_q;

    pulse_qualifier #(
        .SYNC_STAGES (SYNC_STAGES),
        .THRESH      (THRESH),
        .MIN_HIGH    (MIN_HIGH)
    ) u_up (
        .clk   (clk),
        .reset (reset),
        .in    (UP_in),
        .out   (up_q)
    );

    pulse_qualifier #(
        .SYNC_STAGES (SYNC_STAGES),
        .THRESH      (THRESH),
        .MIN_HIGH    (MIN_HIGH)
    ) u_dn (
        .clk   (clk),
        .reset (reset),
        .in    (DN_in),
        .out   (dn_q)
    );

    // Output registers with conflict gating: UP and DN are never driven high together.
    always_ff @(posedge clk) begin
        if (reset) begin
            UP_out <= 1'b0;
            DN_out <= 1'b0;
        end else begin
            UP_out <= up_q & ~dn_q;
            DN_out <= dn_q & ~up_q;
        end
    end

endmodule

// File: tb/tb_digital_filter.sv
// Directed bench for digital_filter: default-parameter instance plus a THRESH=3
// instance. Clock period 10, posedges at 5+10k; outputs sampled at multiples of 10.
module tb_digital_filter;

    logic clk;
    logic reset;
    logic up_in, dn_in, up_out, dn_out;
    logic up3_in, dn3_in, up3_out, dn3_out;

    int n_assert = 0;
    int n_fail   = 0;

    digital_filter dut (
        .clk    (clk),
        .reset  (reset),
        .UP_in  (up_in),
        .DN_in  (dn_in),
        .UP_out (up_out),
        .DN_out (dn_out)
    );

    digital_filter #(
        .SYNC_STAGES (2),
        .THRESH      (3),
        .MIN_HIGH    (1)
    ) dut3 (
        .clk    (clk),
        .reset  (reset),
        .UP_in  (up3_in),
        .DN_in  (dn3_in),
        .UP_out (up3_out),
        .DN_out (dn3_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic goto(input longint t);
        if (t > longint'($time)) #(t - longint'($time));
    endtask

    task automatic check(input string tag, input logic obs, input logic exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b at t=%0t", tag, obs, exp, $time);
        end
    endtask

    initial begin
        reset  = 1'b1;
        up_in  = 1'b0;
        dn_in  = 1'b0;
        up3_in = 1'b0;
        dn3_in = 1'b0;

        // 1: reset with toggling inputs; outputs stay 0
        goto(2);  up_in = 1'b1; dn_in = 1'b0;
        goto(7);  up_in = 1'b0; dn_in = 1'b1;
        goto(10); check("rst_up_10", up_out, 1'b0);
                  check("rst_dn_10", dn_out, 1'b0);
                  check("rst_up3_10", up3_out, 1'b0);
        goto(12); up_in = 1'b1; dn_in = 1'b1;
        goto(17); up_in = 1'b0; dn_in = 1'b0;
        goto(20); check("rst_up_20", up_out, 1'b0);
                  check("rst_dn_20", dn_out, 1'b0);
                  check("rst_dn3_20", dn3_out, 1'b0);
                  reset = 1'b0;

        // 2: pulse between edges is never seen
        goto(30); up_in = 1'b1;
        goto(32); up_in = 1'b0;
        goto(40); check("nopose_up_40", up_out, 1'b0);
        goto(50); check("nopose_up_50", up_out, 1'b0);

        // 3: UP pulse sampled at 55 and 65 -> high 75..95
        goto(52); up_in = 1'b1;
        goto(60); check("up_lat_60", up_out, 1'b0);
        goto(67); up_in = 1'b0;
        goto(70); check("up_lat_70", up_out, 1'b0);
        goto(80); check("up_high_80", up_out, 1'b1);
                  check("up_dn_80", dn_out, 1'b0);
        goto(87); dn_in = 1'b1;
        goto(89); dn_in = 1'b0;
        goto(90); check("up_high_90", up_out, 1'b1);
        goto(100); check("up_fall_100", up_out, 1'b0);

        // 4: DN glitch suppressed; single-sample DN pulse held by MIN_HIGH
        check("dn_glitch_100", dn_out, 1'b0);
        goto(109); dn_in = 1'b1;
        goto(110); check("dn_glitch_110", dn_out, 1'b0);
        goto(124); dn_in = 1'b0;
        goto(130); check("dn_lat_130", dn_out, 1'b0);
        goto(140); check("dn_high_140", dn_out, 1'b1);
                   check("dn_up_140", up_out, 1'b0);
        goto(150); check("dn_hold_150", dn_out, 1'b1);
        goto(160); check("dn_fall_160", dn_out, 1'b0);

        // 5: UP and DN together -> conflict keeps both low
        goto(170); up_in = 1'b1; dn_in = 1'b1;
        for (int t = 180; t <= 250; t += 10) begin
            goto(t);
            if (t == 210) begin
                up_in = 1'b0;
                dn_in = 1'b0;
            end
            check($sformatf("conf_up_%0d", t), up_out, 1'b0);
            check($sformatf("conf_dn_%0d", t), dn_out, 1'b0);
        end

        // 6: reset while UP_out high; input still high re-qualifies after release
        goto(260); up_in = 1'b1;
        goto(280); check("rq_pre_280", up_out, 1'b0);
        goto(290); check("rq_high_290", up_out, 1'b1);
        goto(292); reset = 1'b1;
        goto(300); check("rq_rst_300", up_out, 1'b0);
        goto(302); reset = 1'b0;
        goto(310); check("rq_after_310", up_out, 1'b0);
        goto(320); check("rq_after_320", up_out, 1'b0);
        goto(330); check("rq_again_330", up_out, 1'b1);
        goto(332); up_in = 1'b0;
        goto(350); check("rq_hold_350", up_out, 1'b1);
        goto(360); check("rq_fall_360", up_out, 1'b0);

        // THRESH=3: two-sample pulse rejected
        goto(372); up3_in = 1'b1;
        goto(392); up3_in = 1'b0;
        for (int t = 380; t <= 440; t += 10) begin
            goto(t);
            check($sformatf("t3_short_%0d", t), up3_out, 1'b0);
        end

        // THRESH=3: three-sample pulse passes, rises at edge 5, falls 3 edges later
        goto(452); up3_in = 1'b1;
        goto(482); up3_in = 1'b0;
        goto(490); check("t3_lat_490", up3_out, 1'b0);
        goto(500); check("t3_high_500", up3_out, 1'b1);
                   check("t3_dn_500", dn3_out, 1'b0);
        goto(510); check("t3_high_510", up3_out, 1'b1);
        goto(520); check("t3_high_520", up3_out, 1'b1);
        goto(530); check("t3_fall_530", up3_out, 1'b0);

        goto(540);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
